freqsel_ctrl: RTL

FREQSEL_CTRL -- requirements
Module: freqsel_ctrl

---
 rtl/freqsel_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/freqsel_ctrl.sv
// -----------------------------------------------------------------------------
// freqsel_ctrl
//
// Glitch-safe frequency select controller. A request for a new frequency index
// first gates the downstream clock (clk_en low), waits GATE_CYCLES, moves the
// mux select, waits SETTLE_CYCLES for the mux output to settle, then re-enables
// the clock and pulses done. Requests for the current index, or for an illegal
// index (6..7), complete immediately with a done pulse (plus err if illegal).
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The requester must hold req_valid/req_sel
// stable until accepted; requests seen while busy are dropped, not queued.
//
// Optional feature: define FREQSEL_CTRL_CNT_EN to add the switch_cnt output,
// a saturating count of completed frequency switches.
//
// Parameters:
//   GATE_CYCLES   (1..255) cycles clk_en is low before freq_sel changes
//   SETTLE_CYCLES (1..255) cycles after the freq_sel change before clk_en rises
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request presented
//   req_sel[2:0]in   requested frequency index (0..5 legal)
//   req_ready   out  controller idle, request may be accepted
//   freq_sel    out  registered downstream mux select
//   clk_en      out  registered clock gate enable (1 = clock passed)
//   busy        out  switch sequence in progress
//   done        out  one-cycle pulse on request completion
//   err         out  one-cycle pulse when an illegal index is accepted
//   switch_cnt  out  completed-switch count (FREQSEL_CTRL_CNT_EN only)
//   state_dbg   out  current FSM state (0 IDLE, 1 GATE, 2 SETTLE)
// -----------------------------------------------------------------------------
module freqsel_ctrl #(
   parameter int unsigned GATE_CYCLES   = 4,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [2:0] req_sel,
   output logic       req_ready,
   output logic [2:0] freq_sel,
   output logic       clk_en,
   output logic       busy,
   output logic       done,
   output logic       err,
`ifdef FREQSEL_CTRL_CNT_EN
   output logic [7:0] switch_cnt,
`endif
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATE   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   // The counter is loaded with (length - 1) on state entry and counts down;
   // the state ends on the edge where it reads zero, so it never wraps.
   localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [2:0] MAX_SEL     = 3'd5;

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] target;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         freq_sel <= 3'd0;
         clk_en   <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         cnt      <= 8'd0;
         target   <= 3'd0;
`ifdef FREQSEL_CTRL_CNT_EN
         switch_cnt <= 8'd0;
`endif
      end else begin
         // done/err are single-cycle pulses unless set below.
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_sel > MAX_SEL) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else if (req_sel == freq_sel) begin
                     done <= 1'b1;
                  end else begin
                     target <= req_sel;
                     clk_en <= 1'b0;
                     cnt    <= GATE_LOAD;
                     state  <= GATE;
                  end
               end
            end
            GATE: begin
               // clk_en has been low for the whole gate window, so the
               // select may move here without producing a runt pulse.
               if (cnt == 8'd0) begin
                  freq_sel <= target;
                  cnt      <= SETTLE_LOAD;
                  state    <= SETTLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  clk_en <= 1'b1;
                  done   <= 1'b1;
                  cnt    <= 8'd0;
                  state  <= IDLE;
`ifdef FREQSEL_CTRL_CNT_EN
                  if (switch_cnt != 8'hFF) begin
                     switch_cnt <= switch_cnt + 8'd1;
                  end
`endif
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule
